multicycle_control: RTL

Multi-cycle sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and it stalls on a memory ready handshake. It drives the same control lines as the single-cycle decoder (MemToReg, MemToRead, MemToWrite, OpAlu, RegWrite), plus the PC, IR and mux selects. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

---
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The master modport belongs to the sequencer. The slave modport belongs to the datapath.
interface multicycle_control_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       OpCode;
   logic             MemReady;
   logic             MemToReg;
   logic             MemToRead;
   logic             MemToWrite;
   logic [2:0]       OpAlu;
   logic             RegWrite;
   logic             RegDst;
   logic             IorD;
   logic             IRWrite;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             AluSrcA;
   logic [1:0]       AluSrcB;
   logic [1:0]       PCSource;
   logic [3:0]       State;
   logic [CNT_W-1:0] InstrCount;
   logic             IllegalOp;

   modport master (
      input  OpCode, MemReady,
      output MemToReg, MemToRead, MemToWrite, OpAlu,
      output RegWrite, RegDst, IorD, IRWrite,
      output PCWrite, PCWriteCond, AluSrcA, AluSrcB,
      output PCSource, State, InstrCount, IllegalOp
   );

   modport slave (
      output OpCode, MemReady,
      input  MemToReg, MemToRead, MemToWrite, OpAlu,
      input  RegWrite, RegDst, IorD, IRWrite,
      input  PCWrite, PCWriteCond, AluSrcA, AluSrcB,
      input  PCSource, State, InstrCount, IllegalOp
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer with a memory-ready stall.
// It also keeps a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_control #(
   parameter int         CNT_W     = 16,
   parameter logic [2:0] ALU_ADD   = 3'b000,
   parameter logic [2:0] ALU_SUB   = 3'b001,
   parameter logic [2:0] ALU_FUNCT = 3'b010
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_illegal;

   logic w_is_r, w_is_lw, w_is_sw;
   logic w_is_beq, w_is_addi, w_is_j;
   logic w_illegal, w_retire;

   logic       w_mem_to_reg, w_mem_read, w_mem_write;
   logic [2:0] w_op_alu;
   logic       w_reg_write, w_reg_dst, w_iord;
   logic       w_ir_write, w_pc_write, w_pc_cond;
   logic       w_src_a;
   logic [1:0] w_src_b, w_pc_src;

   assign w_is_r    = (bus.OpCode == OP_R);
   assign w_is_lw   = (bus.OpCode == OP_LW);
   assign w_is_sw   = (bus.OpCode == OP_SW);
   assign w_is_beq  = (bus.OpCode == OP_BEQ);
   assign w_is_addi = (bus.OpCode == OP_ADDI);
   assign w_is_j    = (bus.OpCode == OP_J);
   assign w_illegal = ~(w_is_r | w_is_lw | w_is_sw |
                        w_is_beq | w_is_addi | w_is_j);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:      w_next = S_FETCH;
         S_FETCH:     if (bus.MemReady) w_next = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               w_is_lw,
               w_is_sw:   w_next = S_MEM_ADDR;
               w_is_r:    w_next = S_EXECUTE;
               w_is_beq:  w_next = S_BRANCH;
               w_is_j:    w_next = S_JUMP;
               w_is_addi: w_next = S_ADDI_EXEC;
               default:   w_next = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            if (w_is_sw)      w_next = S_MEM_WRITE;
            else if (w_is_lw) w_next = S_MEM_READ;
            else              w_next = S_FETCH;
         end
         S_MEM_READ:  if (bus.MemReady) w_next = S_MEM_WB;
         S_MEM_WB:    w_next = S_FETCH;
         S_MEM_WRITE: if (bus.MemReady) w_next = S_FETCH;
         S_EXECUTE:   w_next = S_ALU_WB;
         S_ALU_WB:    w_next = S_FETCH;
         S_BRANCH:    w_next = S_FETCH;
         S_JUMP:      w_next = S_FETCH;
         S_ADDI_EXEC: w_next = S_ADDI_WB;
         S_ADDI_WB:   w_next = S_FETCH;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_mem_to_reg = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_op_alu     = 3'b000;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_iord       = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_cond    = 1'b0;
      w_src_a      = 1'b0;
      w_src_b      = 2'b00;
      w_pc_src     = 2'b00;
      unique case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            w_src_b    = 2'b01;
            w_op_alu   = ALU_ADD;
            w_ir_write = bus.MemReady;
            w_pc_write = bus.MemReady;
         end
         // Branch target is precomputed here while the opcode is decoded
         S_DECODE: begin
            w_src_b  = 2'b11;
            w_op_alu = ALU_ADD;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            w_src_a  = 1'b1;
            w_src_b  = 2'b10;
            w_op_alu = ALU_ADD;
         end
         S_MEM_READ: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
         end
         S_MEM_WB: begin
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
         end
         S_EXECUTE: begin
            w_src_a  = 1'b1;
            w_op_alu = ALU_FUNCT;
         end
         S_ALU_WB: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
         end
         S_BRANCH: begin
            w_src_a   = 1'b1;
            w_op_alu  = ALU_SUB;
            w_pc_cond = 1'b1;
            w_pc_src  = 2'b01;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b10;
         end
         S_ADDI_WB:   w_reg_write = 1'b1;
         default: ;
      endcase
   end

   assign w_retire = (r_state == S_MEM_WB)  |
                     (r_state == S_ALU_WB)  |
                     (r_state == S_BRANCH)  |
                     (r_state == S_JUMP)    |
                     (r_state == S_ADDI_WB) |
                     ((r_state == S_MEM_WRITE) & bus.MemReady);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_illegal <= 1'b0;
      end else begin
         if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == S_DECODE && w_illegal)
            r_illegal <= 1'b1;
      end
   end

   assign bus.MemToReg    = w_mem_to_reg;
   assign bus.MemToRead   = w_mem_read;
   assign bus.MemToWrite  = w_mem_write;
   assign bus.OpAlu       = w_op_alu;
   assign bus.RegWrite    = w_reg_write;
   assign bus.RegDst      = w_reg_dst;
   assign bus.IorD        = w_iord;
   assign bus.IRWrite     = w_ir_write;
   assign bus.PCWrite     = w_pc_write;
   assign bus.PCWriteCond = w_pc_cond;
   assign bus.AluSrcA     = w_src_a;
   assign bus.AluSrcB     = w_src_b;
   assign bus.PCSource    = w_pc_src;
   assign bus.State       = r_state;
   assign bus.InstrCount  = r_cnt;
   assign bus.IllegalOp   = r_illegal;

endmodule
